// File: rtl/beamform_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : beamform_pkg
//  Description : Shared widths and sample types for the delay-and-sum
//                beamforming combiner.
//  Revision    : 1.0  - initial release
// ============================================================================
package beamform_pkg;

  localparam int DEFAULT_BIT_WIDTH = 24;
  localparam int DEFAULT_MAX_DELAY = 16;

  // One microphone sample and one full-precision four-way sum.
  typedef logic signed [DEFAULT_BIT_WIDTH-1:0] sample_t;
  typedef logic signed [DEFAULT_BIT_WIDTH+1:0] sum_t;

endpackage : beamform_pkg
`default_nettype wire

// File: rtl/sample_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : sample_delay_line
//  Description : One channel's circular sample buffer. Reads the sample that
//                is 'delay' sets old (read-before-write), bypasses the buffer
//                for a zero delay, and forces 0 while the requested delay
//                reaches back past what has been written since reset.
//  Revision    : 1.0  - initial release
// ============================================================================
module sample_delay_line
  import beamform_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int MAX_DELAY = DEFAULT_MAX_DELAY,
  parameter int DELAY_W   = $clog2(MAX_DELAY)
) (
  input  logic                        sck,
  input  logic                        rst_in,
  input  logic                        wr_en,
  input  logic [DELAY_W-1:0]          wr_ptr,
  input  logic [DELAY_W-1:0]          fill,
  input  logic [DELAY_W-1:0]          delay,
  input  logic signed [BIT_WIDTH-1:0] sample,
  output logic signed [BIT_WIDTH-1:0] delayed
);

  logic signed [BIT_WIDTH-1:0] mem [MAX_DELAY];
  logic [DELAY_W-1:0]          rd_addr;
  logic signed [BIT_WIDTH-1:0] tap;

  // Tap selection: modulo subtract wraps naturally since depth is a power of two.
  always_comb begin
    rd_addr = wr_ptr - delay;
    if (delay > fill) begin
      tap = '0;
    end else if (delay == '0) begin
      tap = sample;
    end else begin
      tap = mem[rd_addr];
    end
  end

  // Buffer write; contents deliberately survive reset.
  always_ff @(posedge sck) begin
    if (wr_en) begin
      mem[wr_ptr] <= sample;
    end
  end

  // S1 register holding this channel's aligned sample.
  always_ff @(posedge sck) begin
    if (!rst_in) begin
      delayed <= '0;
    end else if (wr_en) begin
      delayed <= tap;
    end
  end

endmodule : sample_delay_line
`default_nettype wire

// File: rtl/delay_and_sum.sv
`default_nettype none
// ============================================================================
//  Module      : delay_and_sum
//  Description : Four-channel fixed-delay beamforming combiner. Aligns each
//                microphone by a programmable sample delay and sums the four
//                aligned samples at full precision through a 3-stage pipeline.
//  Revision    : 1.0  - initial release
// ============================================================================
module delay_and_sum
  import beamform_pkg::*;
#(
  parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH,
  parameter int MAX_DELAY = DEFAULT_MAX_DELAY,
  parameter int DELAY_W   = $clog2(MAX_DELAY)
) (
  input  logic                        sck,
  input  logic                        rst_in,
  input  logic signed [BIT_WIDTH-1:0] audio_in1,
  input  logic signed [BIT_WIDTH-1:0] audio_in2,
  input  logic signed [BIT_WIDTH-1:0] audio_in3,
  input  logic signed [BIT_WIDTH-1:0] audio_in4,
  input  logic                        audio_valid_in,
  input  logic [DELAY_W-1:0]          delay1,
  input  logic [DELAY_W-1:0]          delay2,
  input  logic [DELAY_W-1:0]          delay3,
  input  logic [DELAY_W-1:0]          delay4,
  input  logic                        delay_load,
  output logic signed [BIT_WIDTH+1:0] audio_out,
  output logic                        audio_valid_out
);

  localparam logic [DELAY_W-1:0] FILL_MAX = DELAY_W'(MAX_DELAY - 1);

  logic [DELAY_W-1:0]          wr_ptr;
  logic [DELAY_W-1:0]          fill;
  logic [DELAY_W-1:0]          dly    [4];
  logic signed [BIT_WIDTH-1:0] ch_in  [4];
  logic signed [BIT_WIDTH-1:0] s1     [4];
  logic signed [BIT_WIDTH:0]   sum12;
  logic signed [BIT_WIDTH:0]   sum34;
  logic                        v1;
  logic                        v2;

  assign ch_in[0] = audio_in1;
  assign ch_in[1] = audio_in2;
  assign ch_in[2] = audio_in3;
  assign ch_in[3] = audio_in4;

  // Shared write pointer and saturating count of sets written since reset.
  always_ff @(posedge sck) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (audio_valid_in) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill != FILL_MAX) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Delay registers; a sample arriving in the load cycle still sees the old values.
  always_ff @(posedge sck) begin
    if (!rst_in) begin
      dly[0] <= '0;
      dly[1] <= '0;
      dly[2] <= '0;
      dly[3] <= '0;
    end else if (delay_load) begin
      dly[0] <= delay1;
      dly[1] <= delay2;
      dly[2] <= delay3;
      dly[3] <= delay4;
    end
  end

  generate
    for (genvar k = 0; k < 4; k++) begin : g_ch
      sample_delay_line #(
        .BIT_WIDTH (BIT_WIDTH),
        .MAX_DELAY (MAX_DELAY),
        .DELAY_W   (DELAY_W)
      ) u_line (
        .sck     (sck),
        .rst_in  (rst_in),
        .wr_en   (audio_valid_in),
        .wr_ptr  (wr_ptr),
        .fill    (fill),
        .delay   (dly[k]),
        .sample  (ch_in[k]),
        .delayed (s1[k])
      );
    end
  endgenerate

  // S1 valid tracks the delay-line output registers.
  always_ff @(posedge sck) begin
    if (!rst_in) begin
      v1 <= 1'b0;
    end else begin
      v1 <= audio_valid_in;
    end
  end

  // S2: sign-extended pair sums.
  always_ff @(posedge sck) begin
    if (!rst_in) begin
      v2    <= 1'b0;
      sum12 <= '0;
      sum34 <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        sum12 <= (BIT_WIDTH+1)'(s1[0]) + (BIT_WIDTH+1)'(s1[1]);
        sum34 <= (BIT_WIDTH+1)'(s1[2]) + (BIT_WIDTH+1)'(s1[3]);
      end
    end
  end

  // S3: final sum, held between valid pulses.
  always_ff @(posedge sck) begin
    if (!rst_in) begin
      audio_valid_out <= 1'b0;
      audio_out       <= '0;
    end else begin
      audio_valid_out <= v2;
      if (v2) begin
        audio_out <= (BIT_WIDTH+2)'(sum12) + (BIT_WIDTH+2)'(sum34);
      end
    end
  end

endmodule : delay_and_sum
`default_nettype wire
